// File: rtl/song_rom_sequencer_if.sv
// ROM read port of the song sequencer: the sequencer is the only master,
// the ROM answers rom_rdata one cycle after a cycle with rom_en high.
interface song_rom_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [13:0]       rom_rdata;

  modport master (output rom_en, output rom_addr, input rom_rdata);
  modport slave  (input rom_en, input rom_addr, output rom_rdata);
endinterface

// File: rtl/song_rom_sequencer.sv
// Song ROM sequencer for PLAY (duration timer) and LEARN (one note per keypress).
// Optional SONG_LOOP_EN: the end of a song restarts it from its base instead of finishing.
module song_rom_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 64,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode_i,
  input  logic                  start_i,
  input  logic [1:0]            song_sel_i,
  input  logic                  learn_adv_i,
  song_rom_sequencer_if.master  rom,
  output logic [9:0]            note_out_o,
  output logic                  note_valid_o,
  output logic                  busy_o,
  output logic                  song_done_o,
  output logic [2:0]            state_o
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FETCH      = 3'd1;
  localparam logic [2:0] LOAD       = 3'd2;
  localparam logic [2:0] PLAY_HOLD  = 3'd3;
  localparam logic [2:0] LEARN_HOLD = 3'd4;
  localparam logic [2:0] FINISH     = 3'd5;

  localparam logic [1:0] MODE_PLAY  = 2'b01;
  localparam logic [1:0] MODE_LEARN = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              adv_q;
  logic [9:0]        note_q, note_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic        adv_edge;
  logic        last_idx;
  logic        adv_req;
  logic        end_req;
  logic [3:0]  dur_units;
  logic [31:0] hold_len;

  assign adv_edge  = learn_adv_i & ~adv_q;
  assign last_idx  = (idx_q == ADDR_W'(SONG_LEN - 1));
  // A zero duration is played as one unit so a bad word never stalls playback.
  assign dur_units = (rom.rom_rdata[13:10] == 4'd0) ? 4'd1 : rom.rom_rdata[13:10];
  assign hold_len  = 32'(dur_units) * 32'(TICK_DIV) - 32'd1;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    note_d     = note_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    adv_req    = 1'b0;
    end_req    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && (mode_i == MODE_PLAY || mode_i == MODE_LEARN)) begin
          base_d  = ADDR_W'(32'(song_sel_i) * 32'(SONG_LEN));
          idx_d   = '0;
          mode_d  = mode_i;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (rom.rom_rdata[9:2] == 8'd0) begin
          end_req = 1'b1;
        end else begin
          note_d  = rom.rom_rdata[9:0];
          valid_d = 1'b1;
          cnt_d   = hold_len;
          state_d = (mode_q == MODE_PLAY) ? PLAY_HOLD : LEARN_HOLD;
        end
      end
      PLAY_HOLD: begin
        if (cnt_q == 32'd0) adv_req = 1'b1;
        else                cnt_d   = cnt_q - 32'd1;
      end
      LEARN_HOLD: adv_req = adv_edge;
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    if (adv_req) begin
      valid_d = 1'b0;
      if (last_idx) begin
        end_req = 1'b1;
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = FETCH;
      end
    end

    if (end_req) begin
      valid_d = 1'b0;
      note_d  = '0;
      done_d  = 1'b1;
`ifdef SONG_LOOP_EN
      idx_d   = '0;
      state_d = FETCH;
`else
      state_d = FINISH;
`endif
    end

    // Leaving the mode the song was started in abandons it silently.
    if (state_q != IDLE && mode_i != mode_q) begin
      state_d = IDLE;
      valid_d = 1'b0;
      note_d  = '0;
      done_d  = 1'b0;
    end

    rom_en_d   = (state_d == FETCH);
    rom_addr_d = (state_d == FETCH) ? (base_d + idx_d) : rom_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      mode_q     <= '0;
      cnt_q      <= '0;
      adv_q      <= 1'b0;
      note_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      adv_q      <= learn_adv_i;
      note_q     <= note_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom.rom_en   = rom_en_q;
  assign rom.rom_addr = rom_addr_q;
  assign note_out_o   = note_q;
  assign note_valid_o = valid_q;
  assign busy_o       = (state_q != IDLE);
  assign song_done_o  = done_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_song_rom_sequencer.sv
// Directed bench for song_rom_sequencer (TICK_DIV=4, SONG_LEN=8) with a registered ROM model.
module tb_song_rom_sequencer;
  localparam int ADDR_W = 8;
  localparam bit LOOP =
`ifdef SONG_LOOP_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       start = 1'b0;
  logic [1:0] song_sel = 2'b00;
  logic       learn_adv = 1'b0;
  logic [9:0] note_out;
  logic       note_valid, busy, song_done;
  logic [2:0] state;
  logic [13:0] mem [256];
  int total = 0;
  int bad = 0;

  song_rom_sequencer_if #(.ADDR_W(ADDR_W)) rom_if ();

  song_rom_sequencer #(.ADDR_W(ADDR_W), .SONG_LEN(8), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .start_i(start), .song_sel_i(song_sel),
    .learn_adv_i(learn_adv), .rom(rom_if.master), .note_out_o(note_out),
    .note_valid_o(note_valid), .busy_o(busy), .song_done_o(song_done), .state_o(state)
  );

  always #5 clk = ~clk;

  // ROM answers one cycle after the strobe.
  always @(posedge clk) if (rom_if.rom_en) rom_if.rom_rdata <= mem[rom_if.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (the cycle after start was sampled).
  task automatic start_song(input logic [1:0] m, input logic [1:0] sel);
    mode = m; song_sel = sel; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_song();
    mode = 2'b00;
    tick(); tick();
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({rom_if.rom_en, rom_if.rom_addr, note_out, note_valid, busy, song_done} !== '0) begin
      bad++;
      $display("FAIL %s: en=%0b addr=%0d note=%h valid=%0b busy=%0b done=%0b, required all 0",
               name, rom_if.rom_en, rom_if.rom_addr, note_out, note_valid, busy, song_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_play_basic();
    logic exp_valid, exp_busy, exp_done;
    start_song(2'b01, 2'd1);
    total++;
    if (rom_if.rom_en !== 1'b1 || rom_if.rom_addr !== 8'd8) begin
      bad++; $display("FAIL play_first_fetch: en=%0b addr=%0d required en=1 addr=8", rom_if.rom_en, rom_if.rom_addr);
    end
    for (int c = 1; c <= 24; c++) begin
      exp_valid = (c >= 3 && c <= 10) || (c >= 13 && c <= 20);
      exp_done  = (c == 23);
      exp_busy  = LOOP ? 1'b1 : (c <= 23);
      total++;
      if ({note_valid, song_done, busy} !== {exp_valid, exp_done, exp_busy}) begin
        bad++;
        $display("FAIL play_cycle%0d: valid/done/busy=%b required %b", c,
                 {note_valid, song_done, busy}, {exp_valid, exp_done, exp_busy});
      end
      if (c == 3 || c == 13) begin
        total++;
        if (note_out !== ((c == 3) ? {8'h41, 2'd1} : {8'h42, 2'd2})) begin
          bad++; $display("FAIL play_note_c%0d: note=%h", c, note_out);
        end
      end
      if (c < 24) tick();
    end
    abort_song();
  endtask

  task automatic test_learn();
    int fetches;
    start_song(2'b10, 2'd2);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (note_valid !== 1'b1 || note_out !== {8'h10, 2'd0} || state !== 3'd4) begin
      bad++; $display("FAIL learn_wait: valid=%0b note=%h state=%0d required 1 040 4", note_valid, note_out, state);
    end
    learn_adv = 1'b1;
    tick();
    learn_adv = 1'b0;
    total++;
    if (note_valid !== 1'b0 || rom_if.rom_en !== 1'b1 || rom_if.rom_addr !== 8'd17) begin
      bad++; $display("FAIL learn_pulse_adv: valid=%0b en=%0b addr=%0d required 0 1 17", note_valid, rom_if.rom_en, rom_if.rom_addr);
    end
    tick(); tick();
    learn_adv = 1'b1;
    fetches = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rom_if.rom_en) fetches++;
    end
    total++;
    if (fetches != 1 || rom_if.rom_addr !== 8'd18 || note_valid !== 1'b1) begin
      bad++; $display("FAIL learn_held: fetches=%0d addr=%0d valid=%0b required 1 18 1", fetches, rom_if.rom_addr, note_valid);
    end
    learn_adv = 1'b0;
    tick(); tick(); tick();
    total++;
    if (rom_if.rom_addr !== 8'd18 || note_valid !== 1'b1) begin
      bad++; $display("FAIL learn_release: addr=%0d valid=%0b required 18 1", rom_if.rom_addr, note_valid);
    end
    abort_song();
  endtask

  task automatic test_dur_zero();
    int held;
    held = 0;
    start_song(2'b01, 2'd3);
    for (int c = 1; c <= 8; c++) begin
      if (note_valid) held++;
      tick();
    end
    total++;
    if (held != 4) begin
      bad++; $display("FAIL dur_zero: held=%0d cycles required 4", held);
    end
    abort_song();
  endtask

  task automatic test_song_len_end();
    int dones;
    dones = 0;
    start_song(2'b01, 2'd0);
    for (int c = 1; c <= 50; c++) begin
      if (song_done) dones++;
      if (c == 43) begin
        total++;
        if (rom_if.rom_en !== 1'b1 || rom_if.rom_addr !== 8'd7) begin
          bad++; $display("FAIL len_last_fetch: en=%0b addr=%0d required 1 7", rom_if.rom_en, rom_if.rom_addr);
        end
      end
      if (c == 49) begin
        total++;
        if (song_done !== 1'b1 || rom_if.rom_en !== LOOP || rom_if.rom_addr !== (LOOP ? 8'd0 : 8'd7)) begin
          bad++; $display("FAIL len_end: done=%0b en=%0b addr=%0d", song_done, rom_if.rom_en, rom_if.rom_addr);
        end
      end
      if (c == 50) begin
        total++;
        if (busy !== LOOP) begin
          bad++; $display("FAIL len_busy: busy=%0b required %0b", busy, LOOP);
        end
      end
      tick();
    end
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL len_done_count: dones=%0d required 1", dones);
    end
    abort_song();
  endtask

  task automatic test_abort_and_ignored_start();
    int dones;
    dones = 0;
    start_song(2'b01, 2'd1);
    for (int i = 0; i < 4; i++) tick();
    song_sel = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 6; c < 11; c++) begin
      if (song_done) dones++;
      tick();
    end
    total++;
    if (rom_if.rom_en !== 1'b1 || rom_if.rom_addr !== 8'd9) begin
      bad++; $display("FAIL busy_start_ignored: en=%0b addr=%0d required 1 9", rom_if.rom_en, rom_if.rom_addr);
    end
    tick(); tick(); tick();
    total++;
    if (note_valid !== 1'b1 || note_out !== {8'h42, 2'd2}) begin
      bad++; $display("FAIL abort_pre: valid=%0b note=%h required 1 10a", note_valid, note_out);
    end
    mode = 2'b00;
    tick();
    check_idle_outputs_note("abort_mode_change");
    for (int i = 0; i < 3; i++) begin
      if (song_done) dones++;
      tick();
    end
    total++;
    if (dones != 0 || state !== 3'd0) begin
      bad++; $display("FAIL abort_no_done: dones=%0d state=%0d required 0 0", dones, state);
    end
    start_song(2'b00, 2'd1);
    total++;
    if (busy !== 1'b0 || rom_if.rom_en !== 1'b0) begin
      bad++; $display("FAIL start_mode00: busy=%0b en=%0b required 0 0", busy, rom_if.rom_en);
    end
    start_song(2'b11, 2'd1);
    total++;
    if (busy !== 1'b0 || rom_if.rom_en !== 1'b0) begin
      bad++; $display("FAIL start_mode11: busy=%0b en=%0b required 0 0", busy, rom_if.rom_en);
    end
    mode = 2'b00;
    tick();
  endtask

  // After an abort rom_addr legitimately keeps its last value.
  task automatic check_idle_outputs_note(input string name);
    total++;
    if ({note_out, note_valid, busy, song_done} !== '0) begin
      bad++;
      $display("FAIL %s: note=%h valid=%0b busy=%0b done=%0b, required all 0",
               name, note_out, note_valid, busy, song_done);
    end
  endtask

  task automatic test_reset_mid_song();
    start_song(2'b01, 2'd1);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    check_idle_outputs("reset_mid_song");
    rst_n = 1'b1;
    start_song(2'b01, 2'd3);
    total++;
    if (rom_if.rom_en !== 1'b1 || rom_if.rom_addr !== 8'd24) begin
      bad++; $display("FAIL restart_base: en=%0b addr=%0d required 1 24", rom_if.rom_en, rom_if.rom_addr);
    end
    abort_song();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = {4'd0, 8'(i + 1), 2'd0};
    mem[8]  = {4'd2, 8'h41, 2'd1};
    mem[9]  = {4'd2, 8'h42, 2'd2};
    mem[16] = {4'd1, 8'h10, 2'd0};
    mem[17] = {4'd1, 8'h10, 2'd0};
    mem[18] = {4'd1, 8'h10, 2'd0};
    mem[24] = {4'd0, 8'h20, 2'd3};
    rom_if.rom_rdata = '0;
    @(negedge clk);
    test_reset();
    test_play_basic();
    test_learn();
    test_dur_zero();
    test_song_len_end();
    test_abort_and_ignored_start();
    test_reset_mid_song();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
